// File: rtl/viterbi_ctrl_if.sv
// Handshake and datapath-control bundle for the Viterbi decoder sequencer.
//   master : symbol source, path-metric MSBs and survivor memory read data (drives start,
//            sym_valid, pm_msb, surv_rd_data; observes everything else)
//   slave  : the viterbi_ctrl sequencer (drives sym_ready, pm_init, acs_en, pm_norm,
//            surv_wr_*, surv_rd_en/addr, dec_*, busy, done)
interface viterbi_ctrl_if #(
    parameter int SW = 3,
    parameter int AW = 8
);
    localparam int NS = 2 ** SW;

    logic          start;
    logic          sym_valid;
    logic          sym_ready;
    logic          pm_init;
    logic          acs_en;
    logic [NS-1:0] pm_msb;
    logic          pm_norm;
    logic          surv_wr_en;
    logic [AW-1:0] surv_wr_addr;
    logic          surv_rd_en;
    logic [AW-1:0] surv_rd_addr;
    logic [NS-1:0] surv_rd_data;
    logic          dec_valid;
    logic          dec_bit;
    logic [AW-1:0] dec_addr;
    logic          busy;
    logic          done;

    modport master (
        output start, sym_valid, pm_msb, surv_rd_data,
        input  sym_ready, pm_init, acs_en, pm_norm, surv_wr_en, surv_wr_addr,
               surv_rd_en, surv_rd_addr, dec_valid, dec_bit, dec_addr, busy, done
    );

    modport slave (
        input  start, sym_valid, pm_msb, surv_rd_data,
        output sym_ready, pm_init, acs_en, pm_norm, surv_wr_en, surv_wr_addr,
               surv_rd_en, surv_rd_addr, dec_valid, dec_bit, dec_addr, busy, done
    );
endinterface

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder sequencer. Steps the ACS array once per accepted symbol, writes the
// selection vector for time t into survivor memory, flags metric normalisation, then
// traces back from state 0 (read one cycle, decode the next) emitting bits BLK_LEN-1..0
// and pulses done.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active high
//   bus   : viterbi_ctrl_if slave modport (symbol handshake, ACS/PM control, survivor
//           memory write/read, decoded-bit strobe, busy/done status)
module viterbi_ctrl #(
    parameter int SW      = 3,
    parameter int BLK_LEN = 256,
    parameter int AW      = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    viterbi_ctrl_if.slave bus
);
    localparam logic [AW-1:0] LAST_T = AW'(BLK_LEN - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_ACS     = 3'd2;
    localparam logic [2:0] S_TB_RD   = 3'd3;
    localparam logic [2:0] S_TB_CALC = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    r_state, w_state_nxt;
    logic [AW-1:0] r_t, w_t_nxt;
    logic [SW-1:0] r_tb_state, w_tb_state_nxt;
    logic          w_step;
    logic          w_calc;
    logic          w_sel;

    assign w_step = (r_state == S_ACS) & bus.sym_valid;
    assign w_calc = (r_state == S_TB_CALC);
    // Survivor bit of the state currently being traced; 1 selects the path_1 predecessor.
    assign w_sel  = bus.surv_rd_data[r_tb_state];

    always_comb begin
        w_state_nxt    = r_state;
        w_t_nxt        = r_t;
        w_tb_state_nxt = r_tb_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                w_t_nxt     = '0;
                w_state_nxt = S_ACS;
            end
            S_ACS: begin
                if (w_step) begin
                    if (r_t == LAST_T) begin
                        // Last symbol: traceback starts at the final time index from state 0.
                        w_state_nxt    = S_TB_RD;
                        w_t_nxt        = LAST_T;
                        w_tb_state_nxt = '0;
                    end else begin
                        w_t_nxt = r_t + AW'(1);
                    end
                end
            end
            S_TB_RD: begin
                w_state_nxt = S_TB_CALC;
            end
            S_TB_CALC: begin
                // Predecessor of s is {sel, s[SW-1:1]}.
                w_tb_state_nxt = {w_sel, r_tb_state[SW-1:1]};
                if (r_t == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_t_nxt     = r_t - AW'(1);
                    w_state_nxt = S_TB_RD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_tb_state <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_tb_state <= w_tb_state_nxt;
        end
    end

    assign bus.busy         = (r_state != S_IDLE);
    assign bus.pm_init      = (r_state == S_INIT);
    assign bus.sym_ready    = (r_state == S_ACS);
    assign bus.acs_en       = w_step;
    assign bus.surv_wr_en   = w_step;
    assign bus.surv_wr_addr = w_step ? r_t : '0;
    // Normalise when every metric has crossed the half-range point.
    assign bus.pm_norm      = w_step & (&bus.pm_msb);
    assign bus.surv_rd_en   = (r_state == S_TB_RD);
    assign bus.surv_rd_addr = (r_state == S_TB_RD) ? r_t : '0;
    assign bus.dec_valid    = w_calc;
    assign bus.dec_bit      = w_calc & r_tb_state[0];
    assign bus.dec_addr     = w_calc ? r_t : '0;
    assign bus.done         = (r_state == S_DONE);
endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: cycle-level behavioural model plus directed
// literal checks and randomized blocks.
module tb_viterbi_ctrl;
    localparam int SW      = 2;
    localparam int BLK_LEN = 4;
    localparam int AW      = 3;
    localparam int NS      = 2 ** SW;

    localparam int PH_IDLE = 0;
    localparam int PH_INIT = 1;
    localparam int PH_ACS  = 2;
    localparam int PH_TB   = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    viterbi_ctrl_if #(.SW(SW), .AW(AW)) bus ();

    viterbi_ctrl #(.SW(SW), .BLK_LEN(BLK_LEN), .AW(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [NS-1:0] surv_mem [2**AW];
    logic          exp_bits [BLK_LEN];

    int init_cyc[$];
    int step_cyc[$];
    int step_addr[$];
    int rd_cyc[$];
    int dec_cyc[$];
    int dec_addr_q[$];
    int dec_bit_q[$];
    int done_cyc[$];

    // Model state: phase, symbols accepted so far, traceback cycle index.
    int m_ph = PH_IDLE;
    int m_n  = 0;
    int m_k  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        init_cyc.delete(); step_cyc.delete(); step_addr.delete(); rd_cyc.delete();
        dec_cyc.delete(); dec_addr_q.delete(); dec_bit_q.delete(); done_cyc.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Survivor memory: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        if (bus.surv_rd_en === 1'b1) bus.surv_rd_data <= surv_mem[bus.surv_rd_addr];
        else                         bus.surv_rd_data <= NS'($urandom);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= PH_IDLE;
            m_n  <= 0;
            m_k  <= 0;
        end else begin
            case (m_ph)
                PH_IDLE: if (bus.start === 1'b1) m_ph <= PH_INIT;
                PH_INIT: begin m_ph <= PH_ACS; m_n <= 0; end
                PH_ACS: begin
                    if (bus.sym_valid === 1'b1) begin
                        m_n <= m_n + 1;
                        if (m_n + 1 == BLK_LEN) begin m_ph <= PH_TB; m_k <= 0; end
                    end
                end
                PH_TB: begin
                    m_k <= m_k + 1;
                    if (m_k + 1 == 2 * BLK_LEN) m_ph <= PH_DONE;
                end
                default: m_ph <= PH_IDLE;
            endcase
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        bit step, rd, calc;
        int idx;
        step = (m_ph == PH_ACS) && (bus.sym_valid === 1'b1);
        rd   = (m_ph == PH_TB) && (m_k % 2 == 0);
        calc = (m_ph == PH_TB) && (m_k % 2 == 1);
        idx  = BLK_LEN - 1 - m_k / 2;
        check("busy",       32'(bus.busy),       32'(m_ph != PH_IDLE));
        check("pm_init",    32'(bus.pm_init),    32'(m_ph == PH_INIT));
        check("sym_ready",  32'(bus.sym_ready),  32'(m_ph == PH_ACS));
        check("acs_en",     32'(bus.acs_en),     32'(step));
        check("surv_wr_en", 32'(bus.surv_wr_en), 32'(step));
        check("pm_norm",    32'(bus.pm_norm),    32'(step && (&bus.pm_msb)));
        check("surv_rd_en", 32'(bus.surv_rd_en), 32'(rd));
        check("dec_valid",  32'(bus.dec_valid),  32'(calc));
        check("done",       32'(bus.done),       32'(m_ph == PH_DONE));
        if (step) check("surv_wr_addr", 32'(bus.surv_wr_addr), 32'(m_n));
        if (rd)   check("surv_rd_addr", 32'(bus.surv_rd_addr), 32'(idx));
        if (calc) begin
            check("dec_addr", 32'(bus.dec_addr), 32'(idx));
            check("dec_bit",  32'(bus.dec_bit),  32'(exp_bits[idx]));
        end
        if (bus.pm_init === 1'b1) init_cyc.push_back(cyc);
        if (bus.acs_en === 1'b1) begin
            step_cyc.push_back(cyc);
            step_addr.push_back(int'(bus.surv_wr_addr));
        end
        if (bus.surv_rd_en === 1'b1) rd_cyc.push_back(cyc);
        if (bus.dec_valid === 1'b1) begin
            dec_cyc.push_back(cyc);
            dec_addr_q.push_back(int'(bus.dec_addr));
            dec_bit_q.push_back(int'(bus.dec_bit));
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
    end

    // Traceback from state 0 following the survivor rule, newest time index first.
    function automatic void ref_traceback();
        int s;
        s = 0;
        for (int t = BLK_LEN - 1; t >= 0; t--) begin
            exp_bits[t] = 1'(s % 2);
            s = (int'(surv_mem[t][s]) * (NS / 2)) + (s / 2);
        end
    endfunction

    // Forward-encode u through the trellis and plant the winning survivor bits; the
    // decoded bits must then be u itself (u must end in SW zeros).
    task automatic setup_encoded(input logic u [BLK_LEN]);
        int prev, cur;
        prev = 0;
        for (int t = 0; t < BLK_LEN; t++) begin
            cur = ((prev * 2) + int'(u[t])) % NS;
            surv_mem[t] = NS'($urandom);
            surv_mem[t][cur] = 1'(prev / (NS / 2));
            exp_bits[t] = u[t];
            prev = cur;
        end
    endtask

    // vmode 0: valid held, 1: toggling, 2: random, 3: pm_norm directed, 4: start ignored.
    task automatic run_block(input int vmode, output bit ok);
        int cnt;
        ok  = 1'b0;
        cnt = 0;
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.pm_msb = ($urandom_range(0, 2) == 0) ? '1 : NS'($urandom);
            case (vmode)
                0: bus.sym_valid = 1'b1;
                1: bus.sym_valid = (cnt % 2 == 1);
                2: bus.sym_valid = 1'($urandom_range(0, 1));
                3: begin
                    bus.sym_valid = (cnt != 3);
                    if (cnt == 1) bus.pm_msb = '1;
                    if (cnt == 2) bus.pm_msb = NS'(NS - 2);
                    if (cnt == 3) bus.pm_msb = '1;
                end
                default: begin
                    bus.sym_valid = 1'b1;
                    bus.start = (cnt == 2);
                end
            endcase
            if (vmode == 3 && cnt >= 1 && cnt <= 3) begin
                #1;
                check("pm_norm_directed", 32'(bus.pm_norm), (cnt == 1) ? 32'd1 : 32'd0);
            end
            cnt++;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin ok = 1'b1; break; end
        end
        bus.sym_valid = 1'b0;
        bus.start     = 1'b0;
        if (!ok) check("block_done_timeout", 32'd0, 32'd1);
        if (vmode == 4 && ok) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int exp_wr [BLK_LEN];
        int exp_dec [BLK_LEN];
        logic u [BLK_LEN];
        logic ok;
        bit got;
        exp_wr  = '{0, 1, 2, 3};
        exp_dec = '{3, 2, 1, 0};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sym_valid = 1'b0;
        bus.pm_msb = '0;
        for (int t = 0; t < 2**AW; t++) surv_mem[t] = '0;
        for (int t = 0; t < BLK_LEN; t++) exp_bits[t] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Held valid, all-zero survivors.
        clear_logs();
        run_block(0, ok);
        check("b1_pm_init_count", init_cyc.size(), 1);
        check("b1_step_count", step_addr.size(), 4);
        for (int i = 0; i < step_addr.size() && i < 4; i++) begin
            check("b1_wr_addr", step_addr[i], exp_wr[i]);
            if (i > 0) check("b1_step_gap", step_cyc[i] - step_cyc[i-1], 1);
        end
        check("b1_dec_count", dec_addr_q.size(), 4);
        for (int i = 0; i < dec_addr_q.size() && i < 4; i++) begin
            check("b1_dec_addr", dec_addr_q[i], exp_dec[i]);
            check("b1_dec_bit", dec_bit_q[i], 0);
            if (i < rd_cyc.size()) check("b1_rd_to_dec", dec_cyc[i] - rd_cyc[i], 1);
        end
        check("b1_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && dec_cyc.size() == 4 && step_cyc.size() == 4) begin
            check("b1_done_after_dec", done_cyc[0] - dec_cyc[3], 1);
            check("b1_latency", done_cyc[0] - step_cyc[3], 9);
        end
        check("b1_idle_after", 32'(bus.busy), 32'd0);

        // Toggling valid.
        clear_logs();
        run_block(1, ok);
        check("b2_step_count", step_addr.size(), 4);
        for (int i = 0; i < step_addr.size() && i < 4; i++) begin
            check("b2_wr_addr", step_addr[i], exp_wr[i]);
            if (i > 0) check("b2_step_gap", step_cyc[i] - step_cyc[i-1], 2);
        end

        // Hand-traced path u = 1,1,0,0 (states 1,3,2,0).
        for (int t = 0; t < BLK_LEN; t++) surv_mem[t] = NS'($urandom);
        surv_mem[3][0] = 1'b1;
        surv_mem[2][2] = 1'b1;
        surv_mem[1][3] = 1'b0;
        surv_mem[0][1] = 1'b0;
        ref_traceback();
        check("model_pin_t0", 32'(exp_bits[0]), 32'd1);
        check("model_pin_t1", 32'(exp_bits[1]), 32'd1);
        check("model_pin_t2", 32'(exp_bits[2]), 32'd0);
        check("model_pin_t3", 32'(exp_bits[3]), 32'd0);
        clear_logs();
        run_block(2, ok);
        check("b3_dec_count", dec_bit_q.size(), 4);
        for (int i = 0; i < dec_bit_q.size() && i < 4; i++)
            check("b3_dec_bit", dec_bit_q[i], (exp_dec[i] < 2) ? 1 : 0);

        // pm_norm directed.
        run_block(3, ok);

        // start during ACS and DONE must be ignored.
        clear_logs();
        run_block(4, ok);
        repeat (3) @(posedge clk);
        #1;
        check("b5_pm_init_count", init_cyc.size(), 1);
        check("b5_idle", 32'(bus.busy), 32'd0);

        // Reset during traceback decode.
        for (int t = 0; t < BLK_LEN; t++) surv_mem[t] = NS'($urandom);
        ref_traceback();
        clear_logs();
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.sym_valid = 1'b1;
            @(posedge clk); #1;
            if (bus.dec_valid === 1'b1) begin got = 1'b1; break; end
        end
        bus.sym_valid = 1'b0;
        check("rst_reach_tb_calc", 32'(got), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy_now", 32'(bus.busy), 32'd0);
        check("rst_dec_valid_now", 32'(bus.dec_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_busy_edge", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (2 * BLK_LEN + 4) @(posedge clk);
        #1;
        check("rst_no_done", done_cyc.size(), 0);

        // Randomized blocks.
        for (int b = 0; b < 8; b++) begin
            if (b % 2 == 0) begin
                for (int t = 0; t < BLK_LEN; t++) surv_mem[t] = NS'($urandom);
                ref_traceback();
            end else begin
                for (int t = 0; t < BLK_LEN; t++)
                    u[t] = (t < BLK_LEN - SW) ? 1'($urandom_range(0, 1)) : 1'b0;
                setup_encoded(u);
            end
            clear_logs();
            run_block(2, ok);
            check("rnd_dec_count", dec_bit_q.size(), BLK_LEN);
            if (b % 2 == 1)
                for (int i = 0; i < dec_bit_q.size() && i < BLK_LEN; i++)
                    check("rnd_decoded_eq_input", dec_bit_q[i], int'(u[BLK_LEN - 1 - i]));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
